mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port benchmark data memory (`mem`, 32-bit words, 1-cycle registered read) between `NREQ` requesters, e.g. the core's load/store unit and the test-harness loader/checker. It accepts at most one access per cycle, drives the memory port, and routes the read-back word to the requester that issued it one cycle later. It also supports locked bursts so a requester can hold the port across consecutive accesses.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_picker.sv | 42 ++++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the benchmark-memory arbiter.
// Imported by mem_arbiter and rr_picker.
package mem_arb_pkg;

  localparam int MEM_DATA_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Width of a requester id; at least 1 bit even for tiny NREQ.
  function automatic int clog2_nreq(input int nreq);
    int bits;
    bits = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < nreq) bits = k + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Searches last+1, last+2, ... (mod NREQ), or only the owner while locked.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = clog2_nreq(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  input  logic            locked,
  input  logic [IDW-1:0]  owner,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    w_idx     = '0;
    if (locked) begin
      // The owner alone may use the port; an idle owner leaves it unused.
      grant_any    = req[owner];
      grant[owner] = req[owner];
      grant_id     = owner;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        w_idx = IDW'((int'(last) + k) % NREQ);
        if (!grant_any && req[w_idx]) begin
          grant_any    = 1'b1;
          grant[w_idx] = 1'b1;
          grant_id     = w_idx;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port benchmark memory between
// NREQ requesters, with locked bursts and a one-cycle response pipeline.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_LEN = 11,
  parameter int NREQ     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_we,
  input  logic [NREQ-1:0]              req_lock,
  input  logic [NREQ*ADDR_LEN-1:0]     req_addr,
  input  logic [NREQ*MEM_DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]              req_ready,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [MEM_DATA_W-1:0]        rsp_data,
  output logic [ADDR_LEN-1:0]          mem_addr,
  output logic                         mem_wr_req,
  output logic [MEM_DATA_W-1:0]        mem_wr_data,
  input  logic [MEM_DATA_W-1:0]        mem_rd_data
);

  localparam int IDW = clog2_nreq(NREQ);

  arb_state_t          r_state, w_state_next;
  logic [IDW-1:0]      r_owner, w_owner_next;
  logic [IDW-1:0]      r_last, w_last_next;
  logic                r_pend_valid;
  logic [IDW-1:0]      r_pend_id;

  logic [NREQ-1:0]     w_grant;
  logic [IDW-1:0]      w_grant_id;
  logic                w_grant_any;
  logic                w_accept;

  logic [ADDR_LEN-1:0]   w_addr  [NREQ];
  logic [MEM_DATA_W-1:0] w_wdata [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_addr[gi]    = req_addr[gi*ADDR_LEN +: ADDR_LEN];
      assign w_wdata[gi]   = req_wdata[gi*MEM_DATA_W +: MEM_DATA_W];
      assign rsp_valid[gi] = r_pend_valid && (r_pend_id == IDW'(gi));
    end
  endgenerate

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req       (req_valid),
    .last      (r_last),
    .locked    (r_state == LOCKED),
    .owner     (r_owner),
    .grant     (w_grant),
    .grant_id  (w_grant_id),
    .grant_any (w_grant_any)
  );

  // No grant is issued while reset is held.
  assign w_accept  = w_grant_any & ~rst;
  assign req_ready = w_grant & {NREQ{~rst}};
  assign rsp_data  = mem_rd_data;

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    if (w_accept) begin
      if (req_lock[w_grant_id]) begin
        w_state_next = LOCKED;
        w_owner_next = w_grant_id;
      end else begin
        w_state_next = IDLE;
        w_last_next  = w_grant_id;
      end
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_req  = 1'b0;
    mem_wr_data = '0;
    if (w_accept) begin
      mem_addr    = w_addr[w_grant_id];
      mem_wr_req  = req_we[w_grant_id];
      mem_wr_data = w_wdata[w_grant_id];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last       <= IDW'(NREQ - 1);
      r_pend_valid <= 1'b0;
      r_pend_id    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last       <= w_last_next;
      r_pend_valid <= w_accept;
      r_pend_id    <= w_grant_id;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// traffic compared against a round-robin/lock reference model.
module tb_mem_arbiter;

  localparam int AW = 11;
  localparam int N  = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid, req_we, req_lock, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, mem_wr_data, mem_rd_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_req;
  logic [AW-1:0]   t_addr  [N];
  logic [DW-1:0]   t_wdata [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_addr[gi*AW +: AW]  = t_addr[gi];
    assign req_wdata[gi*DW +: DW] = t_wdata[gi];
  end

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_LEN(AW), .NREQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_addr    (mem_addr),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Benchmark memory: registered read, read-before-write, rd_data reset to 0.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk or posedge rst) begin
    if (rst) mem_rd_data <= '0;
    else begin
      mem_rd_data <= mem[mem_addr];
      if (mem_wr_req) mem[mem_addr] <= mem_wr_data;
    end
  end

  // Reference model state
  int            m_last, m_owner, m_pend_id;
  bit            m_locked, m_pend_valid;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_mem [2**AW];

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0]  exp_ready, exp_rsp_valid, obs_ready, obs_rsp_valid;
  logic [DW-1:0] exp_rsp_data, exp_wdata, obs_rsp_data, obs_wdata;
  logic [AW-1:0] exp_addr, obs_addr;
  logic          exp_wr, obs_wr;

  task automatic model_reset();
    m_last = N - 1; m_owner = 0; m_locked = 0; m_pend_valid = 0; m_pend_id = 0;
  endtask

  function automatic int model_pick();
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v; req_we[i] = we; req_lock[i] = lk; t_addr[i] = a; t_wdata[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock with current inputs: predict, sample at negedge, advance model.
  task automatic cycle();
    int g;
    g = model_pick();
    exp_ready = '0; exp_addr = '0; exp_wr = 1'b0; exp_wdata = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1; exp_addr = t_addr[g]; exp_wr = req_we[g]; exp_wdata = t_wdata[g];
    end
    exp_rsp_valid = '0;
    if (m_pend_valid) exp_rsp_valid[m_pend_id] = 1'b1;
    exp_rsp_data = m_pend_data;
    @(negedge clk);
    obs_ready = req_ready; obs_rsp_valid = rsp_valid; obs_rsp_data = rsp_data;
    obs_addr = mem_addr; obs_wr = mem_wr_req; obs_wdata = mem_wr_data;
    @(posedge clk);
    if (g >= 0) begin
      $display("[TB] t=%0t grant=%0d we=%0b addr=%0d wdata=%h", $time, g, req_we[g], t_addr[g], t_wdata[g]);
      m_pend_data = m_mem[t_addr[g]];
      if (req_we[g]) m_mem[t_addr[g]] = t_wdata[g];
      if (req_lock[g]) begin m_locked = 1; m_owner = g; end
      else begin m_locked = 0; m_last = g; end
    end
    m_pend_valid = (g >= 0);
    m_pend_id = (g >= 0) ? g : 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 1'b0, AW'(i + 5), 32'hdead);
    @(negedge clk);
    n_tests += 5;
    if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b want 0", req_ready); end
    if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    if (mem_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr_req got %b want 0", mem_wr_req); end
    if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    @(posedge clk); #1;
    idle_all();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b0, 1'b0, 11'd0, '0);
    cycle();
    n_tests++;
    if (obs_ready !== 2'b01 || obs_ready !== exp_ready)
      begin n_fail++; $display("FAIL single_ready got %b want 01", obs_ready); end
    idle_all();
    cycle();
    n_tests += 2;
    if (obs_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid got %b want 01", obs_rsp_valid); end
    if (obs_rsp_data !== 32'heb) begin n_fail++; $display("FAIL single_rsp_data got %h want eb", obs_rsp_data); end
  endtask

  task automatic test_alternate();
    set_req(0, 1'b1, 1'b0, 1'b0, 11'd1, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 11'd255, '0);
    for (int c = 0; c < 7; c++) begin
      if (c == 6) idle_all();
      cycle();
      n_tests++;
      if (obs_ready !== exp_ready || obs_rsp_valid !== exp_rsp_valid)
        begin n_fail++; $display("FAIL alt_handshake c%0d got %b/%b want %b/%b", c, obs_ready, obs_rsp_valid, exp_ready, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        n_tests++;
        if (obs_rsp_data !== exp_rsp_data)
          begin n_fail++; $display("FAIL alt_rsp_data c%0d got %h want %h", c, obs_rsp_data, exp_rsp_data); end
      end
    end
  endtask

  task automatic test_write_read();
    set_req(1, 1'b1, 1'b1, 1'b0, 11'd100, 32'h1234);
    cycle();
    n_tests += 2;
    if (obs_ready !== 2'b10) begin n_fail++; $display("FAIL wr_ready got %b want 10", obs_ready); end
    if ({obs_wr, obs_addr, obs_wdata} !== {1'b1, 11'd100, 32'h1234})
      begin n_fail++; $display("FAIL wr_mem_drive got %b/%0d/%h want 1/100/1234", obs_wr, obs_addr, obs_wdata); end
    idle_all();
    set_req(0, 1'b1, 1'b0, 1'b0, 11'd100, '0);
    cycle();
    n_tests += 2;
    if (obs_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL wr_rsp_valid got %b want 10", obs_rsp_valid); end
    if (obs_rsp_data !== 32'h0) begin n_fail++; $display("FAIL wr_old_data got %h want 0", obs_rsp_data); end
    idle_all();
    cycle();
    n_tests += 2;
    if (obs_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_after_wr_valid got %b want 01", obs_rsp_valid); end
    if (obs_rsp_data !== 32'h1234) begin n_fail++; $display("FAIL rd_after_wr_data got %h want 1234", obs_rsp_data); end
  endtask

  task automatic test_lock_burst();
    logic [N-1:0] want [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    for (int c = 0; c < 5; c++) begin
      if (c < 3) set_req(0, 1'b1, 1'b0, (c < 2), AW'(c), '0);
      else set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1, (c >= 1 && c <= 3), 1'b0, 1'b0, 11'd1, '0);
      cycle();
      n_tests++;
      if (obs_ready !== want[c] || obs_ready !== exp_ready || obs_rsp_valid !== exp_rsp_valid)
        begin n_fail++; $display("FAIL burst_handshake c%0d got %b/%b want %b/%b", c, obs_ready, obs_rsp_valid, want[c], exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        n_tests++;
        if (obs_rsp_data !== exp_rsp_data)
          begin n_fail++; $display("FAIL burst_rsp_data c%0d got %h want %h", c, obs_rsp_data, exp_rsp_data); end
      end
    end
  endtask

  task automatic test_lock_idle();
    logic [N-1:0] want [6] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       set_req(0, 1'b1, 1'b0, 1'b1, 11'd3, '0);
        3:       set_req(0, 1'b1, 1'b0, 1'b0, 11'd4, '0);
        default: set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
      endcase
      set_req(1, (c < 5), 1'b1, 1'b0, 11'd50, 32'ha5a5);
      cycle();
      n_tests += 2;
      if (obs_ready !== want[c] || obs_ready !== exp_ready || obs_rsp_valid !== exp_rsp_valid)
        begin n_fail++; $display("FAIL lockidle_handshake c%0d got %b/%b want %b/%b", c, obs_ready, obs_rsp_valid, want[c], exp_rsp_valid); end
      if (obs_wr !== exp_wr || obs_addr !== exp_addr)
        begin n_fail++; $display("FAIL lockidle_mem c%0d got %b/%0d want %b/%0d", c, obs_wr, obs_addr, exp_wr, exp_addr); end
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b0, 1'b0, 11'd0, '0);
    cycle();
    n_tests++;
    if (obs_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_accept got %b want 01", obs_ready); end
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    n_tests += 2;
    if (rsp_valid !== '0) begin n_fail++; $display("FAIL rstmid_rsp_valid got %b want 0", rsp_valid); end
    if (rsp_data !== '0) begin n_fail++; $display("FAIL rstmid_rsp_data got %h want 0", rsp_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 11'd1, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 11'd255, '0);
    cycle();
    n_tests += 2;
    if (obs_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_priority got %b want 01", obs_ready); end
    if (obs_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_rsp got %b want 00", obs_rsp_valid); end
    idle_all();
    cycle();
  endtask

  task automatic test_random();
    logic [N-1:0] waiting;
    waiting = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!waiting[i])
          set_req(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 15)), $urandom);
      end
      cycle();
      waiting = req_valid & ~exp_ready;
      n_tests += 3;
      if (obs_ready !== exp_ready || obs_rsp_valid !== exp_rsp_valid)
        begin n_fail++; $display("FAIL rand_handshake c%0d got %b/%b want %b/%b", c, obs_ready, obs_rsp_valid, exp_ready, exp_rsp_valid); end
      if ({obs_wr, obs_addr, obs_wdata} !== {exp_wr, exp_addr, exp_wdata})
        begin n_fail++; $display("FAIL rand_mem c%0d got %b/%0d/%h want %b/%0d/%h", c, obs_wr, obs_addr, obs_wdata, exp_wr, exp_addr, exp_wdata); end
      if (exp_rsp_valid != '0 && obs_rsp_data !== exp_rsp_data)
        begin n_fail++; $display("FAIL rand_rsp_data c%0d got %h want %h", c, obs_rsp_data, exp_rsp_data); end
    end
    idle_all();
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 2**AW; a++) begin
      mem[a] = '0; m_mem[a] = '0;
    end
    mem[0] = 32'heb;   m_mem[0] = 32'heb;
    mem[1] = 32'hc4;   m_mem[1] = 32'hc4;
    mem[2] = 32'h55;   m_mem[2] = 32'h55;
    mem[255] = 32'h09; m_mem[255] = 32'h09;
    m_pend_data = '0;
    idle_all();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_lock_burst();
    test_lock_idle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
